// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : ALU execute stage. The registered result sits behind a
//            valid/ready handshake with a one-entry skid, and a synchronous
//            flush is provided. Optional macro ALU_SHIFT_EN enables the shift
//            ops (codes 100/110/111).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [2:0]                alu_control_i,
    input  logic [DATA_WIDTH-1:0]     src_a_i,
    input  logic [DATA_WIDTH-1:0]     src_b_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic                      zero_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;
    localparam int         SHAMT_WIDTH = $clog2(DATA_WIDTH);
`endif

    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      alu_zero;
    logic                      slt_flag;

    logic                      out_valid;
    logic [DATA_WIDTH-1:0]     out_result;
    logic                      out_zero;
    logic [REG_ADDR_WIDTH-1:0] out_rd;

    logic                      skid_full;
    logic [DATA_WIDTH-1:0]     skid_result;
    logic                      skid_zero;
    logic [REG_ADDR_WIDTH-1:0] skid_rd;

    logic                      accept;
    logic                      out_free;

`ifdef ALU_SHIFT_EN
    logic [SHAMT_WIDTH-1:0]    shamt;
    assign shamt = src_b_i[SHAMT_WIDTH-1:0];
`endif

    assign slt_flag = $signed(src_a_i) < $signed(src_b_i);

    always_comb begin
        alu_result = '0;
        case (alu_control_i)
            OP_ADD:  alu_result = src_a_i + src_b_i;
            OP_SUB:  alu_result = src_a_i - src_b_i;
            OP_AND:  alu_result = src_a_i & src_b_i;
            OP_OR:   alu_result = src_a_i | src_b_i;
            OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, slt_flag};
`ifdef ALU_SHIFT_EN
            OP_SLL:  alu_result = src_a_i << shamt;
            OP_SRL:  alu_result = src_a_i >> shamt;
            OP_SRA:  alu_result = DATA_WIDTH'($signed(src_a_i) >>> shamt);
`endif
            default: alu_result = '0;
        endcase
    end

    // Zero flag travels with its result so the output pair is always coherent.
    assign alu_zero = (alu_result == '0);

    // ready_o comes straight from a flop, so there is no path from ready_i.
    assign ready_o  = ~skid_full;
    assign accept   = valid_i & ready_o;
    assign out_free = ~out_valid | ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_rd      <= '0;
            skid_full   <= 1'b0;
            skid_result <= '0;
            skid_zero   <= 1'b0;
            skid_rd     <= '0;
        end else if (flush_i) begin
            // Data registers keep their last value; only the valid state is squashed.
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_valid  <= 1'b1;
                out_result <= skid_result;
                out_zero   <= skid_zero;
                out_rd     <= skid_rd;
                if (accept) begin
                    skid_result <= alu_result;
                    skid_zero   <= alu_zero;
                    skid_rd     <= rd_addr_i;
                end else begin
                    skid_full <= 1'b0;
                end
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_zero   <= alu_zero;
                out_rd     <= rd_addr_i;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full   <= 1'b1;
            skid_result <= alu_result;
            skid_zero   <= alu_zero;
            skid_rd     <= rd_addr_i;
        end
    end

    assign valid_o   = out_valid;
    assign result_o  = out_result;
    assign zero_o    = out_zero;
    assign rd_addr_o = out_rd;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Directed table-driven bench for alu_exec_stage (honours ALU_SHIFT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_addr_i;
    logic        flush;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .alu_control_i(alu_control), .src_a_i(src_a), .src_b_i(src_b),
        .rd_addr_i(rd_addr_i), .flush_i(flush), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result), .zero_o(zero), .rd_addr_o(rd_addr_o)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        valid_i     = v;
        alu_control = c;
        src_a       = a;
        src_b       = b;
        rd_addr_i   = rd;
    endtask

    task automatic set_vec(input int i, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] r, input logic z);
        vecs[i].ctrl       = c;
        vecs[i].a          = a;
        vecs[i].b          = b;
        vecs[i].rd         = rd;
        vecs[i].exp_result = r;
        vecs[i].exp_zero   = z;
    endtask

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            3'd4: return a << b[4:0];
            3'd6: return a >> b[4:0];
            3'd7: return 32'($signed(a) >>> b[4:0]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Leaves A (1+2=3, rd 1) on the output and B (10-3=7, rd 2) in the skid.
    task automatic fill_stage();
        ready_i = 1'b0;
        drive(1'b1, 3'd0, 32'd1, 32'd2, 5'd1);
        tick();
        drive(1'b1, 3'd1, 32'd10, 32'd3, 5'd2);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [4:0]  rd_q[$];
        logic [31:0] ea;
        logic [4:0]  er;

        set_vec(0, 3'd0, 32'd5,        32'd7,        5'd3,  32'd12,         1'b0);
        set_vec(1, 3'd1, 32'd7,        32'd7,        5'd4,  32'd0,          1'b1);
        set_vec(2, 3'd2, 32'hF0,       32'h3C,       5'd5,  32'h30,         1'b0);
        set_vec(3, 3'd3, 32'hF0,       32'h0F,       5'd6,  32'hFF,         1'b0);
        set_vec(4, 3'd5, 32'hFFFFFFFF, 32'd1,        5'd7,  32'd1,          1'b0);
        set_vec(5, 3'd5, 32'd1,        32'hFFFFFFFF, 5'd8,  32'd0,          1'b1);
        set_vec(6, 3'd0, 32'hFFFFFFFF, 32'd1,        5'd9,  32'd0,          1'b1);
        set_vec(7, 3'd1, 32'd0,        32'd1,        5'd10, 32'hFFFFFFFF,   1'b0);
        set_vec(8, 3'd5, 32'h80000000, 32'h7FFFFFFF, 5'd11, 32'd1,          1'b0);
`ifdef ALU_SHIFT_EN
        set_vec(9,  3'd4, 32'd1,        32'd4, 5'd12, 32'd16,        1'b0);
        set_vec(10, 3'd6, 32'h80000000, 32'd4, 5'd13, 32'h08000000,  1'b0);
        set_vec(11, 3'd7, 32'h80000000, 32'd4, 5'd14, 32'hF8000000,  1'b0);
`else
        set_vec(9,  3'd4, 32'd1,        32'd4, 5'd12, 32'd0,         1'b1);
        set_vec(10, 3'd6, 32'h80000000, 32'd4, 5'd13, 32'd0,         1'b1);
        set_vec(11, 3'd7, 32'h80000000, 32'd4, 5'd14, 32'd0,         1'b1);
`endif

        rst_n   = 1'b0;
        flush   = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #23;
        check("reset_valid",  valid_o,   0);
        check("reset_result", result,    0);
        check("reset_zero",   zero,      0);
        check("reset_rd",     rd_addr_o, 0);
        rst_n = 1'b1;
        tick();
        check("reset_ready", ready_o, 1);

        // Single ops, one cycle latency each.
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd);
            tick();
            drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
            check($sformatf("vec%0d_valid", i),  valid_o,   1);
            check($sformatf("vec%0d_result", i), result,    vecs[i].exp_result);
            check($sformatf("vec%0d_zero", i),   zero,      vecs[i].exp_zero);
            check($sformatf("vec%0d_rd", i),     rd_addr_o, vecs[i].rd);
            tick();
            check($sformatf("vec%0d_idle", i),   valid_o,   0);
            check($sformatf("vec%0d_hold", i),   result,    vecs[i].exp_result);
        end

        // Backpressure: A out, B in skid, C refused until the skid drains.
        fill_stage();
        check("bp_ready_low", ready_o, 0);
        check("bp_a_result",  result,  3);
        check("bp_a_rd",      rd_addr_o, 1);
        drive(1'b1, 3'd3, 32'd4, 32'd8, 5'd3);
        tick();
        check("bp_stall_result", result,  3);
        check("bp_stall_ready",  ready_o, 0);
        ready_i = 1'b1;
        tick();
        check("bp_b_valid",  valid_o,   1);
        check("bp_b_result", result,    7);
        check("bp_b_rd",     rd_addr_o, 2);
        check("bp_ready_up", ready_o,   1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("bp_c_result", result,    12);
        check("bp_c_rd",     rd_addr_o, 3);
        tick();
        check("bp_drained", valid_o, 0);

        // Flush with output and skid full plus an incoming op.
        fill_stage();
        drive(1'b1, 3'd0, 32'd100, 32'd1, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("flush_valid", valid_o, 0);
        check("flush_ready", ready_o, 1);
        check("flush_hold",  result,  3);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_quiet%0d", i), valid_o, 0);
        end

        // Flush squashes an op accepted that same cycle.
        drive(1'b1, 3'd0, 32'd2, 32'd2, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("flush_accept_valid", valid_o, 0);
        tick();
        check("flush_accept_quiet", valid_o, 0);

        // Asynchronous reset in the middle of a stall.
        fill_stage();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",  valid_o,   0);
        check("rst_mid_result", result,    0);
        check("rst_mid_zero",   zero,      0);
        check("rst_mid_rd",     rd_addr_o, 0);
        #3;
        rst_n   = 1'b1;
        ready_i = 1'b1;
        tick();
        check("rst_mid_ready", ready_o, 1);
        check("rst_mid_empty", valid_o, 0);

        // Back-to-back streaming against the model.
        ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [2:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            c  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            rd = 5'($urandom_range(0, 31));
            drive(1'b1, c, a, b, rd);
            exp_q.push_back(model(c, a, b));
            rd_q.push_back(rd);
            tick();
            ea = exp_q.pop_front();
            er = rd_q.pop_front();
            check($sformatf("stream%0d_valid", i),  {ready_o, valid_o}, 2'b11);
            check($sformatf("stream%0d_result", i), result,    ea);
            check($sformatf("stream%0d_zero", i),   zero,      (ea == 32'd0));
            check($sformatf("stream%0d_rd", i),     rd_addr_o, er);
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        check("stream_end", valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
